// File: rtl/rr_arb4_if.sv
// Handshake bundle between the requesting blocks and the rr_arb4 arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_arb4_if;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic [7:0] grant_cnt;
    logic       timeout;

    modport master (
        output en, req, done,
        input  grant, grant_id, grant_valid, grant_cnt, timeout
    );

    modport slave (
        input  en, req, done,
        output grant, grant_id, grant_valid, grant_cnt, timeout
    );
endinterface

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter with a held grant released by done or
// by the owner withdrawing its request. Grant is issued one-hot and encoded.
// A mandatory IDLE bubble separates consecutive grants.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that force-releases a
// grant after MAX_HOLD cycles and pulses timeout for one cycle.
module rr_arb4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    rr_arb4_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [3:0] grant_q;
    logic [1:0] grant_id_q;
    logic       grant_valid_q;
    logic [7:0] grant_cnt_q;
    logic       timeout_q;

    logic       pick_vld;
    logic [1:0] pick_id;
    logic       rel_normal;
    logic       rel_force;

    // MAX_HOLD is only meaningful in 2..255; reject other values at elaboration
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in the range 2..255");
    end

    // Scan req starting at ptr and wrapping; the lowest offset with a set bit wins
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_id  = ptr_q + 2'(k);
            end
        end
    end

    // Normal release: owner reports done or stops requesting
    assign rel_normal = (state_q == BUSY) && (bus.done || !bus.req[grant_id_q]);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q;

    // A normal release in the same cycle wins, so no timeout pulse then
    assign rel_force = (state_q == BUSY) && !rel_normal
                       && (hold_q == 8'(MAX_HOLD - 1));

    // Hold counter: cleared when a grant is issued, counts every BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 8'd0;
        end else if (state_q == IDLE) begin
            if (bus.en && pick_vld) begin
                hold_q <= 8'd0;
            end
        end else begin
            hold_q <= hold_q + 8'd1;
        end
    end
`else
    assign rel_force = 1'b0;
`endif

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            grant_q       <= 4'b0000;
            grant_id_q    <= 2'd0;
            grant_valid_q <= 1'b0;
            grant_cnt_q   <= 8'd0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en && pick_vld) begin
                        grant_q       <= 4'b0001 << pick_id;
                        grant_id_q    <= pick_id;
                        grant_valid_q <= 1'b1;
                        grant_cnt_q   <= grant_cnt_q + 8'd1;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    // grant_id keeps its value so the datapath select stays stable
                    if (rel_normal || rel_force) begin
                        grant_q       <= 4'b0000;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_id_q + 2'd1;
                        timeout_q     <= rel_force;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_cnt   = grant_cnt_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Testbench for rr_arb4: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the arbitration rules.
module tb_rr_arb4;

    localparam int MH = 4;

    logic clk;
    logic rst_n;

    rr_arb4_if bus ();

    rr_arb4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model state
    int m_owner;   // -1 when no grant is held
    int m_ptr;
    int m_last;
    int m_cnt;
    int m_hold;    // cycles the current grant has been visible
    int m_issues;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_last  = 0;
        m_cnt   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(input bit en, input logic [3:0] req, input bit done);
        bit found;
        m_to = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            if (en) begin
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % 4;
                    end
                end
            end
            if (found) begin
                m_last = m_owner;
                m_cnt  = (m_cnt + 1) % 256;
                m_hold = 1;
                m_issues++;
            end
        end else begin
            if (done || !req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
`ifdef ARB_TIMEOUT_EN
            end else if (m_hold >= MH) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_to    = 1'b1;
`endif
            end else begin
                m_hold++;
            end
        end
    endfunction

    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic check_all();
        check("grant",       32'(bus.grant),       32'(model_grant()));
        check("grant_id",    32'(bus.grant_id),    32'(m_last));
        check("grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
        check("grant_cnt",   32'(bus.grant_cnt),   32'(m_cnt));
        check("timeout",     32'(bus.timeout),     32'(m_to));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bus.en, bus.req, bus.done);
        #1;
        check_all();
    endtask

    initial begin
        int ids[5];
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        int ngr;
        int cyc;
        int cnt0;
        bit prev_v;

        n_chk    = 0;
        n_pass   = 0;
        m_issues = 0;
        model_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // Reset values
        #12;
        check("rst_grant",   32'(bus.grant),       32'h0);
        check("rst_id",      32'(bus.grant_id),    32'h0);
        check("rst_valid",   32'(bus.grant_valid), 32'h0);
        check("rst_cnt",     32'(bus.grant_cnt),   32'h0);
        check("rst_timeout", 32'(bus.timeout),     32'h0);
        rst_n = 1'b1;
        step();

        // Rotation with all requesting, done one cycle after each grant
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        ngr     = 0;
        cyc     = 0;
        prev_v  = 1'b0;
        while (ngr < 5 && cyc < 40) begin
            bus.done = bus.grant_valid;
            step();
            if (bus.grant_valid && !prev_v) begin
                ids[ngr] = int'(bus.grant_id);
                ngr++;
            end
            prev_v = bus.grant_valid;
            cyc++;
        end
        check("rot_grants", 32'(ngr), 32'd5);
        for (int i = 0; i < 5; i++) check("rot_id", 32'(ids[i]), 32'(exp_ids[i]));
        check("rot_cnt", 32'(bus.grant_cnt), 32'd5);

        // Release owner 0 (ptr -> 1), grant 1, release (ptr -> 2), then req only 0
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0010;
        step();
        check("wrap_first_id", 32'(bus.grant_id), 32'd1);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0001;
        step();
        check("wrap_id",    32'(bus.grant_id), 32'd0);
        check("wrap_grant", 32'(bus.grant),    32'h1);

        // Owner withdraws without done
        bus.req = 4'b0000;
        step();
        check("withdraw_valid", 32'(bus.grant_valid), 32'd0);

        // en low blocks new grants; raising it grants one cycle later
        bus.en  = 1'b0;
        bus.req = 4'b0100;
        for (int i = 0; i < 20; i++) step();
        check("en_low_grant", 32'(bus.grant), 32'h0);
        bus.en = 1'b1;
        step();
        check("en_high_grant", 32'(bus.grant), 32'h4);

        // Simultaneous done and request drop: one release, no extra count
        cnt0     = int'(bus.grant_cnt);
        bus.done = 1'b1;
        bus.req  = 4'b0000;
        step();
        check("dual_rel_valid", 32'(bus.grant_valid), 32'd0);
        check("dual_rel_cnt",   32'(bus.grant_cnt),   32'(cnt0));
        bus.done = 1'b0;
        step();

        // Random traffic until 256 more grants: counter must wrap back
        cnt0     = int'(bus.grant_cnt);
        m_issues = 0;
        cyc      = 0;
        while (m_issues < 256 && cyc < 6000) begin
            bus.en   = ($urandom_range(0, 3) != 0);
            bus.req  = 4'($urandom_range(0, 15));
            bus.done = ($urandom_range(0, 2) == 0);
            step();
            cyc++;
        end
        check("wrap_issues", 32'(m_issues),      32'd256);
        check("cnt_wrap",    32'(bus.grant_cnt), 32'(cnt0));

        // Drain to IDLE, then hold req[2] with done low
        bus.en   = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        bus.req = 4'b0100;
        step();
        check("hold_grant", 32'(bus.grant), 32'h4);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < MH - 1; i++) begin
            step();
            check("hold_valid", 32'(bus.grant_valid), 32'd1);
        end
        step();
        check("to_valid", 32'(bus.grant_valid), 32'd0);
        check("to_pulse", 32'(bus.timeout),     32'd1);
        bus.req = 4'b1111;
        step();
        check("to_pulse_end", 32'(bus.timeout),  32'd0);
        check("to_next_id",   32'(bus.grant_id), 32'd3);
`else
        for (int i = 0; i < 100; i++) step();
        check("hold_valid", 32'(bus.grant_valid), 32'd1);
        check("hold_to",    32'(bus.timeout),     32'd0);
`endif

        // Asynchronous reset in the middle of a BUSY cycle
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(bus.grant),       32'h0);
        check("arst_valid", 32'(bus.grant_valid), 32'h0);
        check("arst_id",    32'(bus.grant_id),    32'h0);
        check("arst_cnt",   32'(bus.grant_cnt),   32'h0);
        model_reset();
        #1;
        rst_n    = 1'b1;
        bus.req  = 4'b1000;
        bus.done = 1'b0;
        bus.en   = 1'b1;
        step();
        check("post_rst_grant", 32'(bus.grant),    32'h8);
        check("post_rst_id",    32'(bus.grant_id), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
